// File: rtl/btb_update_sched.sv
// btb_update_sched: owns the BTB write port; filters/queues EX branch updates and walks all sets on flush.
// Latency: an accepted update into an idle, empty scheduler appears on wr_* one cycle later.
// Backpressure: none toward EX; an update arriving at a full FIFO during a flush is dropped (upd_drop).
// Optional: `define BTB_SCHED_STATS_EN adds saturating counters cnt_wr / cnt_filtered / cnt_dropped.
module btb_update_sched #(
   parameter int SET_ADDR_LEN = 7,
`ifdef BTB_SCHED_STATS_EN
   parameter int CNT_W        = 16,
`endif
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   input  logic        flush_req,
   output logic        wr_req,
   output logic [31:0] wr_pc,
   output logic [31:0] wr_target,
   output logic        wr_taken,
   output logic        flush_busy,
   output logic        flush_done,
`ifdef BTB_SCHED_STATS_EN
   output logic [CNT_W-1:0] cnt_wr,
   output logic [CNT_W-1:0] cnt_filtered,
   output logic [CNT_W-1:0] cnt_dropped,
`endif
   output logic        upd_drop
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_FW = $clog2(FIFO_DEPTH + 1);
   localparam int ENT_W  = 65;   // {taken, target, pc}

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t                  state_q, state_d;
   logic [SET_ADDR_LEN-1:0] idx_q, idx_d, walk_idx;
   logic                    walk_last;

   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_base, rd_base;
   logic [CNT_FW-1:0] cnt_q, cnt_d, cnt_base;

   logic             redundant, accepted, fifo_full, pop, bypass, push, drop;
   logic [ENT_W-1:0] upd_ent, head_ent;

   logic        wr_req_q, wr_req_d, wr_taken_q, wr_taken_d;
   logic [31:0] wr_pc_q, wr_pc_d, wr_target_q, wr_target_d;
   logic        busy_q, busy_d, done_q, done_d, drop_q;

   // Update filtering and FIFO push/pop/bypass decisions
   always_comb begin
      redundant = (upd_pred_taken == upd_taken) && (!upd_taken || (upd_pred_target == upd_target));
      accepted  = upd_valid && !redundant;
      upd_ent   = {upd_taken, upd_target, upd_pc};
      head_ent  = mem_q[rd_ptr_q];
      fifo_full = (cnt_q == CNT_FW'(FIFO_DEPTH));
      // A flush request empties the FIFO first; a same-cycle update then lands in the cleared FIFO.
      pop       = (state_q == IDLE) && !flush_req && (cnt_q != '0);
      bypass    = (state_q == IDLE) && !flush_req && (cnt_q == '0) && accepted;
      push      = accepted && !bypass && (flush_req || pop || !fifo_full);
      drop      = accepted && !bypass && !push;
      wr_base   = flush_req ? '0 : wr_ptr_q;
      rd_base   = flush_req ? '0 : rd_ptr_q;
      cnt_base  = flush_req ? '0 : cnt_q;
      wr_ptr_d  = wr_base + PTR_W'(push);
      rd_ptr_d  = rd_base + PTR_W'(pop);
      cnt_d     = cnt_base + CNT_FW'(push) - CNT_FW'(pop);
   end

   // Walk index for this cycle: a flush request during a walk restarts it at set 0
   always_comb begin
      walk_idx  = flush_req ? '0 : idx_q;
      walk_last = &walk_idx;
   end

   // State register, walk index and FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; data needs no reset since the count guards every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_base] <= upd_ent;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d = FLUSH;
               idx_d   = '0;
            end
         end
         FLUSH: begin
            idx_d = walk_idx + SET_ADDR_LEN'(1);
            if (walk_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: what the registered write port shows next cycle
   always_comb begin
      wr_req_d    = 1'b0;
      wr_pc_d     = '0;
      wr_target_d = '0;
      wr_taken_d  = 1'b0;
      done_d      = 1'b0;
      busy_d      = (state_q == FLUSH) || (state_d == FLUSH);
      case (state_q)
         IDLE: begin
            if (pop) begin
               wr_req_d = 1'b1;
               {wr_taken_d, wr_target_d, wr_pc_d} = head_ent;
            end else if (bypass) begin
               wr_req_d = 1'b1;
               {wr_taken_d, wr_target_d, wr_pc_d} = upd_ent;
            end
         end
         FLUSH: begin
            wr_req_d = 1'b1;
            wr_pc_d  = {{(32-SET_ADDR_LEN-2){1'b0}}, walk_idx, 2'b00};
            done_d   = walk_last;
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_req_q    <= 1'b0;
         wr_pc_q     <= '0;
         wr_target_q <= '0;
         wr_taken_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         wr_req_q    <= wr_req_d;
         wr_pc_q     <= wr_pc_d;
         wr_target_q <= wr_target_d;
         wr_taken_q  <= wr_taken_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         drop_q      <= drop;
      end
   end

   assign wr_req     = wr_req_q;
   assign wr_pc      = wr_pc_q;
   assign wr_target  = wr_target_q;
   assign wr_taken   = wr_taken_q;
   assign flush_busy = busy_q;
   assign flush_done = done_q;
   assign upd_drop   = drop_q;

`ifdef BTB_SCHED_STATS_EN
   logic [CNT_W-1:0] cnt_wr_q, cnt_filt_q, cnt_drop_q;

   // Saturating event counters: update writes, filtered updates, dropped updates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_wr_q   <= '0;
         cnt_filt_q <= '0;
         cnt_drop_q <= '0;
      end else begin
         if ((pop || bypass) && !(&cnt_wr_q)) cnt_wr_q <= cnt_wr_q + CNT_W'(1);
         if (upd_valid && redundant && !(&cnt_filt_q)) cnt_filt_q <= cnt_filt_q + CNT_W'(1);
         if (drop && !(&cnt_drop_q)) cnt_drop_q <= cnt_drop_q + CNT_W'(1);
      end
   end

   assign cnt_wr       = cnt_wr_q;
   assign cnt_filtered = cnt_filt_q;
   assign cnt_dropped  = cnt_drop_q;
`endif

endmodule
